// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Purpose : free-running clock divider and 640x480@60 VGA raster timing (pixel = clock/2).
// Latency : hsync/vsync/inDispArea are registered alongside hcount/vcount, so there is no skew between them.
// Backpress: none; the block free-runs from reset. Optional frame_end strobe under `VGA_FRAME_TICK_EN`.
module vga_timing_gen #(
    parameter int CNT_WIDTH = 24,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [CNT_WIDTH-1:0] out,
    output logic                 pix_en,
    output logic [9:0]           hcount,
    output logic [9:0]           vcount,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 inDispArea
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic                 frame_end
`endif
);

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC;

    logic [9:0] hcountNext;
    logic [9:0] vcountNext;
    logic       hWrap;
    logic       vWrap;

    // Pixel step happens on even divider values, i.e. every other clock.
    assign pix_en = ~out[0];

    // Next raster position; decode registers look at this so they line up with the counters.
    always_comb begin
        hcountNext = hcount;
        vcountNext = vcount;
        hWrap      = (hcount == 10'(H_TOTAL - 1));
        vWrap      = (vcount == 10'(V_TOTAL - 1));
        if (pix_en) begin
            if (hWrap) begin
                hcountNext = 10'd0;
                vcountNext = vWrap ? 10'd0 : vcount + 10'd1;
            end else begin
                hcountNext = hcount + 10'd1;
            end
        end
    end

    // Free-running divider, wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= out + CNT_WIDTH'(1);
        end
    end

    // Raster counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcount <= 10'd0;
            vcount <= 10'd0;
        end else begin
            hcount <= hcountNext;
            vcount <= vcountNext;
        end
    end

    // Sync and display-area decode of the upcoming position, registered with the counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            inDispArea <= 1'b1;
        end else begin
            hsync      <= !((hcountNext >= 10'(H_SYNC_START)) && (hcountNext < 10'(H_SYNC_END)));
            vsync      <= !((vcountNext >= 10'(V_SYNC_START)) && (vcountNext < 10'(V_SYNC_END)));
            inDispArea <= (hcountNext < 10'(H_VISIBLE)) && (vcountNext < 10'(V_VISIBLE));
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Per-frame strobe held for the whole last visible pixel (two clocks).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_end <= 1'b0;
        end else begin
            frame_end <= (hcountNext == 10'(H_VISIBLE - 1)) && (vcountNext == 10'(V_VISIBLE - 1));
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

    // Shrunk raster so several whole frames and divider wraps fit in a short run.
    localparam int SW  = 8;
    localparam int SHV = 40, SHF = 4, SHS = 8, SHB = 6;
    localparam int SVV = 20, SVF = 3, SVS = 2, SVB = 4;
    // Full-size 640x480 instance for line-level timing.
    localparam int DW  = 24;
    localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
    localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [SW-1:0] sOut;
    logic          sPixEn, sHs, sVs, sDe;
    logic [9:0]    sH, sV;
    logic [DW-1:0] dOut;
    logic          dPixEn, dHs, dVs, dDe;
    logic [9:0]    dH, dV;
`ifdef VGA_FRAME_TICK_EN
    logic          sFe, dFe;
`endif

    vga_timing_gen #(
        .CNT_WIDTH(SW), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) uSmall (
        .clock(clock), .reset(reset), .out(sOut), .pix_en(sPixEn),
        .hcount(sH), .vcount(sV), .hsync(sHs), .vsync(sVs), .inDispArea(sDe)
`ifdef VGA_FRAME_TICK_EN
        , .frame_end(sFe)
`endif
    );

    vga_timing_gen #(
        .CNT_WIDTH(DW), .H_VISIBLE(DHV), .H_FP(DHF), .H_SYNC(DHS), .H_BP(DHB),
        .V_VISIBLE(DVV), .V_FP(DVF), .V_SYNC(DVS), .V_BP(DVB)
    ) uFull (
        .clock(clock), .reset(reset), .out(dOut), .pix_en(dPixEn),
        .hcount(dH), .vcount(dV), .hsync(dHs), .vsync(dVs), .inDispArea(dDe)
`ifdef VGA_FRAME_TICK_EN
        , .frame_end(dFe)
`endif
    );

    typedef struct packed {
        logic [31:0] cnt;
        logic        pe;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fe;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    longint t;   // rising edges seen since reset was released

    // Clock edges since release; zero while reset is held.
    always @(posedge clock or posedge reset) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    // Reference: pixel index = ceil(edges/2), then split into column/line of the frame.
    function automatic exp_t refModel(input longint tt, input int w,
                                      input int hv, input int hf, input int hs, input int hb,
                                      input int vv, input int vf, input int vs, input int vb);
        exp_t   e;
        longint ht, vt, n, hh, ll;
        ht    = longint'(hv + hf + hs + hb);
        vt    = longint'(vv + vf + vs + vb);
        n     = ((tt + 1) / 2) % (ht * vt);
        hh    = n % ht;
        ll    = n / ht;
        e.cnt = 32'(tt % (longint'(1) << w));
        e.pe  = ((tt % 2) == 0);
        e.h   = 10'(hh);
        e.v   = 10'(ll);
        e.hs  = !(hh >= hv + hf && hh < hv + hf + hs);
        e.vs  = !(ll >= vv + vf && ll < vv + vf + vs);
        e.de  = (hh < hv) && (ll < vv);
        e.fe  = (hh == hv - 1) && (ll == vv - 1);
        return e;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    // Every clock, compare both instances against the reference model.
    always @(negedge clock) begin
        exp_t es, ed;
        es = refModel(t, SW, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
        ed = refModel(t, DW, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB);
        chk("small.out",    longint'(sOut),   longint'(es.cnt));
        chk("small.pix_en", longint'(sPixEn), longint'(es.pe));
        chk("small.hcount", longint'(sH),     longint'(es.h));
        chk("small.vcount", longint'(sV),     longint'(es.v));
        chk("small.hsync",  longint'(sHs),    longint'(es.hs));
        chk("small.vsync",  longint'(sVs),    longint'(es.vs));
        chk("small.disp",   longint'(sDe),    longint'(es.de));
        chk("full.out",     longint'(dOut),   longint'(ed.cnt));
        chk("full.pix_en",  longint'(dPixEn), longint'(ed.pe));
        chk("full.hcount",  longint'(dH),     longint'(ed.h));
        chk("full.vcount",  longint'(dV),     longint'(ed.v));
        chk("full.hsync",   longint'(dHs),    longint'(ed.hs));
        chk("full.vsync",   longint'(dVs),    longint'(ed.vs));
        chk("full.disp",    longint'(dDe),    longint'(ed.de));
`ifdef VGA_FRAME_TICK_EN
        chk("small.frame_end", longint'(sFe), longint'(es.fe));
        chk("full.frame_end",  longint'(dFe), longint'(ed.fe));
`endif
    end

    // Assert reset between clock edges, check it takes effect at once, then release.
    task automatic doReset(input int holdCycles);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rst.small.out",    longint'(sOut), 0);
        chk("rst.small.hcount", longint'(sH),   0);
        chk("rst.small.vcount", longint'(sV),   0);
        chk("rst.full.out",     longint'(dOut), 0);
        chk("rst.full.pix_en",  longint'(dPixEn), 1);
        chk("rst.full.hcount",  longint'(dH),   0);
        chk("rst.full.vcount",  longint'(dV),   0);
        chk("rst.full.hsync",   longint'(dHs),  1);
        chk("rst.full.vsync",   longint'(dVs),  1);
        chk("rst.full.disp",    longint'(dDe),  1);
`ifdef VGA_FRAME_TICK_EN
        chk("rst.full.frame_end", longint'(dFe), 0);
`endif
        repeat (holdCycles) @(negedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;

        // Run the full-size raster to column 300 and reset in the middle of the line.
        repeat (599) @(posedge clock);
        @(negedge clock);
        chk("pre.full.hcount", longint'(dH), 300);
        doReset(2);
        @(posedge clock);
        #1;
        chk("rel1.full.hcount", longint'(dH), 1);
        chk("rel1.full.out",    longint'(dOut), 1);
        repeat (2) @(posedge clock);
        #1;
        chk("rel3.full.hcount", longint'(dH), 2);

        // Resets at random points in the line/frame.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(4000, 50)) @(posedge clock);
            doReset(int'($urandom_range(4, 1)));
        end

        // Long run: several small frames, divider wraps, and a full-size line wrap.
        repeat (14000) @(posedge clock);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
